// File: rtl/riscv32_core_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcodes, funct3 codes,
// sequencer states, ALU operations and data-memory control encodings.
package riscv32_core_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Arithmetic funct3 (shared by OP and OP-IMM)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Data-memory control: bit 1 = read, bit 0 = write
    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b10;
    localparam logic [1:0] MEM_WRITE = 2'b01;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // Map funct3 plus the "alternate" bit (instr[30]) onto an ALU operation.
    function automatic alu_op_e alu_op_from_funct(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv32_core_alu.sv
// Combinational ALU: arithmetic/logic result plus the three compare flags
// used by the branch unit (equal, signed less-than, unsigned less-than).
module riscv32_alu
    import riscv32_core_pkg::*;
(
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  alu_op_e     alu_op_i,
    output logic [31:0] result_o,
    output logic        eq_o,
    output logic        lt_o,
    output logic        ltu_o
);

    // Compare flags are always computed on the raw operands
    always_comb begin
        eq_o  = (op_a_i == op_b_i);
        lt_o  = ($signed(op_a_i) < $signed(op_b_i));
        ltu_o = (op_a_i < op_b_i);
    end

    // Operation select; shifts use only the low five bits of operand B
    always_comb begin
        result_o = 32'd0;
        case (alu_op_i)
            ALU_ADD:  result_o = op_a_i + op_b_i;
            ALU_SUB:  result_o = op_a_i - op_b_i;
            ALU_SLL:  result_o = op_a_i << op_b_i[4:0];
            ALU_SLT:  result_o = {31'd0, lt_o};
            ALU_SLTU: result_o = {31'd0, ltu_o};
            ALU_XOR:  result_o = op_a_i ^ op_b_i;
            ALU_SRL:  result_o = op_a_i >> op_b_i[4:0];
            ALU_SRA:  result_o = $unsigned($signed(op_a_i) >>> op_b_i[4:0]);
            ALU_OR:   result_o = op_a_i | op_b_i;
            ALU_AND:  result_o = op_a_i & op_b_i;
            default:  result_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/riscv32_core.sv
// Multi-cycle RV32I core. Every instruction walks FETCH, DECODE, EXECUTE,
// MEM, WB (CPI = 5). Register file, instruction and data memory are external
// and word-indexed; all external reads are assumed to settle in one cycle.
// Strobes (write_ctrl_input, mem_ctrl_input) are only ever high in their own
// state; address/data buses always show their derived values.
module riscv32_core
    import riscv32_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] REG_BASE = 32'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ins_data,
    input  logic [31:0] load_pc_reg_value1,
    input  logic [31:0] load_pc_reg_value2,
    input  logic [31:0] read_data,
    output logic        write_ctrl_input,
    output logic [1:0]  mem_ctrl_input,
    output logic [31:0] ins_addr,
    output logic [31:0] load_pc_reg_addr1,
    output logic [31:0] load_pc_reg_addr2,
    output logic [31:0] write_pc_reg_value,
    output logic [31:0] write_pc_reg_addr,
    output logic [31:0] address,
    output logic [31:0] w_data,
    output state_e      dbg_state
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic        taken_q, taken_d;

    // Instruction fields and immediates decoded from IR
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u  = {ir_q[31:12], 12'd0};
    assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    logic [31:0] alu_a, alu_b, alu_res;
    alu_op_e     alu_op;
    logic        alu_eq, alu_lt, alu_ltu;
    logic        branch_cond;
    logic        writes_rd;
    logic        is_load, is_store;
    logic [31:0] pc_plus4, next_pc, wb_value;

    assign pc_plus4 = pc_q + 32'd4;
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);

    riscv32_alu u_alu (
        .op_a_i   (alu_a),
        .op_b_i   (alu_b),
        .alu_op_i (alu_op),
        .result_o (alu_res),
        .eq_o     (alu_eq),
        .lt_o     (alu_lt),
        .ltu_o    (alu_ltu)
    );

    // Sequencer state and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            alu_q   <= 32'd0;
            mdr_q   <= 32'd0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            taken_q <= taken_d;
        end
    end

    // Fixed five-step sequence; each state loads only its own register(s)
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        taken_d = taken_q;
        case (state_q)
            ST_FETCH: begin
                ir_d    = ins_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // x0 reads as zero whatever the external array holds
                a_d     = (rs1 == 5'd0) ? 32'd0 : load_pc_reg_value1;
                b_d     = (rs2 == 5'd0) ? 32'd0 : load_pc_reg_value2;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                alu_d   = alu_res;
                taken_d = branch_cond;
                state_d = ST_MEM;
            end
            ST_MEM: begin
                if (is_load) mdr_d = read_data;
                state_d = ST_WB;
            end
            ST_WB: begin
                pc_d    = next_pc;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // ALU operand and operation selection by opcode
    always_comb begin
        alu_a  = a_q;
        alu_b  = imm_i;
        alu_op = ALU_ADD;
        case (opcode)
            OPC_LUI:    begin alu_a = 32'd0; alu_b = imm_u; end
            OPC_AUIPC:  begin alu_a = pc_q;  alu_b = imm_u; end
            OPC_JALR:   alu_b = imm_i;
            OPC_LOAD:   alu_b = imm_i;
            OPC_STORE:  alu_b = imm_s;
            OPC_BRANCH: alu_b = b_q;
            OPC_OP_IMM: alu_op = alu_op_from_funct(funct3, (funct3 == F3_SR) && ir_q[30]);
            OPC_OP: begin
                alu_b  = b_q;
                alu_op = alu_op_from_funct(funct3, ir_q[30]);
            end
            default: begin alu_a = 32'd0; alu_b = 32'd0; end
        endcase
    end

    // Branch condition from the ALU compare flags
    always_comb begin
        branch_cond = 1'b0;
        case (funct3)
            F3_BEQ:  branch_cond = alu_eq;
            F3_BNE:  branch_cond = !alu_eq;
            F3_BLT:  branch_cond = alu_lt;
            F3_BGE:  branch_cond = !alu_lt;
            F3_BLTU: branch_cond = alu_ltu;
            F3_BGEU: branch_cond = !alu_ltu;
            default: branch_cond = 1'b0;
        endcase
    end

    // Writeback value, destination-write qualifier and next pc
    always_comb begin
        writes_rd = 1'b0;
        wb_value  = alu_q;
        next_pc   = pc_plus4;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP: writes_rd = 1'b1;
            OPC_LOAD: begin
                writes_rd = 1'b1;
                wb_value  = mdr_q;
            end
            OPC_JAL: begin
                writes_rd = 1'b1;
                wb_value  = pc_plus4;
                next_pc   = pc_q + imm_j;
            end
            OPC_JALR: begin
                writes_rd = 1'b1;
                wb_value  = pc_plus4;
                next_pc   = {alu_q[31:1], 1'b0};
            end
            OPC_BRANCH: next_pc = taken_q ? (pc_q + imm_b) : pc_plus4;
            default: ;
        endcase
    end

    // External buses and state-qualified strobes
    always_comb begin
        ins_addr           = {2'b00, pc_q[31:2]};
        load_pc_reg_addr1  = REG_BASE + {27'd0, rs1};
        load_pc_reg_addr2  = REG_BASE + {27'd0, rs2};
        write_pc_reg_addr  = REG_BASE + {27'd0, rd};
        write_pc_reg_value = wb_value;
        address            = {2'b00, alu_q[31:2]};
        w_data             = b_q;
        mem_ctrl_input     = MEM_IDLE;
        if (state_q == ST_MEM && is_load)  mem_ctrl_input = MEM_READ;
        if (state_q == ST_MEM && is_store) mem_ctrl_input = MEM_WRITE;
        write_ctrl_input   = (state_q == ST_WB) && writes_rd && (rd != 5'd0);
        dbg_state          = state_q;
    end

endmodule

// File: tb/tb_riscv32_core.sv
// Bench for riscv32_core: external register/instruction/data arrays plus an
// instruction-level reference model of RV32I. Each instruction is stepped
// through its five cycles and the bus activity is checked against the model.
module tb_riscv32_core;
    import riscv32_core_pkg::*;

    localparam logic [31:0] TB_REG_BASE = 32'd0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ins_data, load_pc_reg_value1, load_pc_reg_value2, read_data;
    logic        write_ctrl_input;
    logic [1:0]  mem_ctrl_input;
    logic [31:0] ins_addr, load_pc_reg_addr1, load_pc_reg_addr2;
    logic [31:0] write_pc_reg_value, write_pc_reg_addr, address, w_data;
    state_e      dbg_state;

    always #5 clk = ~clk;

    riscv32_core dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .ins_data           (ins_data),
        .load_pc_reg_value1 (load_pc_reg_value1),
        .load_pc_reg_value2 (load_pc_reg_value2),
        .read_data          (read_data),
        .write_ctrl_input   (write_ctrl_input),
        .mem_ctrl_input     (mem_ctrl_input),
        .ins_addr           (ins_addr),
        .load_pc_reg_addr1  (load_pc_reg_addr1),
        .load_pc_reg_addr2  (load_pc_reg_addr2),
        .write_pc_reg_value (write_pc_reg_value),
        .write_pc_reg_addr  (write_pc_reg_addr),
        .address            (address),
        .w_data             (w_data),
        .dbg_state          (dbg_state)
    );

    // ---------------- system memory (environment) ----------------
    logic [31:0] imem [256];
    logic [31:0] xreg [32];
    logic [31:0] dmem [64];

    assign ins_data           = imem[ins_addr[7:0]];
    assign load_pc_reg_value1 = xreg[load_pc_reg_addr1[4:0]];
    assign load_pc_reg_value2 = xreg[load_pc_reg_addr2[4:0]];
    assign read_data          = dmem[address[5:0]];

    always @(posedge clk) begin
        if (write_ctrl_input) xreg[write_pc_reg_addr[4:0]] <= write_pc_reg_value;
        if (mem_ctrl_input == 2'b01) dmem[address[5:0]] <= w_data;
    end

    // ---------------- reference model state ----------------
    logic [31:0] mpc;
    logic [31:0] mreg [32];
    logic [31:0] mdmem [64];
    logic        e_wen;
    logic [4:0]  e_rd;
    logic [31:0] e_wval, e_addr, e_wdata;
    logic [1:0]  e_mem;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input int r, input logic [31:0] v);
        xreg[r] = v;
        mreg[r] = v;
    endtask

    function automatic logic [31:0] ref_arith(input logic [2:0] f3, input logic alt,
                                              input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Architectural effect of one instruction; fills e_* and advances the model
    task automatic model_exec(input logic [31:0] ins);
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] v1, v2, i_imm, s_imm, b_imm, u_imm, j_imm, npc, eff;
        logic        wr, cond;
        op  = ins[6:0];
        rd  = ins[11:7];
        f3  = ins[14:12];
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        v1  = (rs1 == 0) ? 32'd0 : mreg[rs1];
        v2  = (rs2 == 0) ? 32'd0 : mreg[rs2];
        i_imm = {{20{ins[31]}}, ins[31:20]};
        s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        b_imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        u_imm = {ins[31:12], 12'd0};
        j_imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        npc = mpc + 4;
        wr = 1'b0; e_wval = 32'd0; e_mem = 2'b00; e_addr = 32'd0; e_wdata = 32'd0;
        case (op)
            7'h37: begin wr = 1; e_wval = u_imm; end
            7'h17: begin wr = 1; e_wval = mpc + u_imm; end
            7'h6f: begin wr = 1; e_wval = mpc + 4; npc = mpc + j_imm; end
            7'h67: begin wr = 1; e_wval = mpc + 4; npc = (v1 + i_imm) & ~32'd1; end
            7'h63: begin
                case (f3)
                    3'd0:    cond = (v1 == v2);
                    3'd1:    cond = (v1 != v2);
                    3'd4:    cond = ($signed(v1) < $signed(v2));
                    3'd5:    cond = ($signed(v1) >= $signed(v2));
                    3'd6:    cond = (v1 < v2);
                    3'd7:    cond = (v1 >= v2);
                    default: cond = 1'b0;
                endcase
                if (cond) npc = mpc + b_imm;
            end
            7'h03: begin
                eff = v1 + i_imm;
                e_mem = 2'b10; e_addr = eff >> 2;
                wr = 1; e_wval = mdmem[e_addr[5:0]];
            end
            7'h23: begin
                eff = v1 + s_imm;
                e_mem = 2'b01; e_addr = eff >> 2; e_wdata = v2;
                mdmem[e_addr[5:0]] = v2;
            end
            7'h13: begin wr = 1; e_wval = ref_arith(f3, (f3 == 3'd5) && ins[30], v1, i_imm); end
            7'h33: begin wr = 1; e_wval = ref_arith(f3, ins[30], v1, v2); end
            default: ;
        endcase
        e_rd  = rd;
        e_wen = wr && (rd != 0);
        if (e_wen) mreg[rd] = e_wval;
        mpc = npc;
    endtask

    // Load an instruction at the current pc and check all five cycles of it
    task automatic run_instr(input logic [31:0] ins);
        imem[mpc[9:2]] = ins;
        model_exec(ins);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                check("rs1_addr", load_pc_reg_addr1, TB_REG_BASE + {27'd0, ins[19:15]});
                check("rs2_addr", load_pc_reg_addr2, TB_REG_BASE + {27'd0, ins[24:20]});
            end
            if (c == 3) begin
                check("mem_ctrl", {30'd0, mem_ctrl_input}, {30'd0, e_mem});
                if (e_mem != 2'b00) check("mem_addr", address, e_addr);
                if (e_mem == 2'b01) check("w_data", w_data, e_wdata);
            end else begin
                check("mem_ctrl_idle", {30'd0, mem_ctrl_input}, 32'd0);
            end
            if (c == 4) begin
                check("wr_en", {31'd0, write_ctrl_input}, {31'd0, e_wen});
                if (e_wen) begin
                    check("wr_addr", write_pc_reg_addr, TB_REG_BASE + {27'd0, e_rd});
                    check("wr_value", write_pc_reg_value, e_wval);
                end
            end else begin
                check("wr_en_idle", {31'd0, write_ctrl_input}, 32'd0);
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("next_ins_addr", ins_addr, mpc >> 2);
        check("state_fetch", {29'd0, dbg_state}, {29'd0, ST_FETCH});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mpc = 32'h0;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [6:0]  nop_ops [4];
        logic [2:0]  br_f3 [6];
        nop_ops = '{7'h0f, 7'h73, 7'h00, 7'h7f};
        br_f3   = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        r   = $urandom;
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        f3  = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 11))
            0:  return {r[31:12], rd, 7'h37};
            1:  return {r[31:12], rd, 7'h17};
            2:  return {r[31:12], rd, 7'h6f};
            3:  return {r[31:20], rs1, 3'd0, rd, 7'h67};
            4, 5: return {r[31:25], rs2, rs1, br_f3[$urandom_range(0, 5)], r[11:7], 7'h63};
            6:  return {r[31:20], rs1, f3, rd, 7'h03};
            7:  return {r[31:25], rs2, rs1, f3, r[11:7], 7'h23};
            8, 11: begin
                if (f3 == 3'd1) return {7'd0, r[24:20], rs1, f3, rd, 7'h13};
                if (f3 == 3'd5) return {1'b0, r[30], 5'd0, r[24:20], rs1, f3, rd, 7'h13};
                return {r[31:20], rs1, f3, rd, 7'h13};
            end
            9: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00;
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            default: return {r[31:7], nop_ops[$urandom_range(0, 3)]};
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
        for (int i = 0; i < 64; i++) begin
            dmem[i]  = $urandom;
            mdmem[i] = dmem[i];
        end
        for (int i = 1; i < 32; i++) set_reg(i, $urandom);
        xreg[0] = 32'hA5A5_0F0F;   // garbage that the core must ignore for x0
        mreg[0] = 32'h0;
        mpc = 32'h0;

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ins_addr", ins_addr, 32'd0);
        check("rst_wen", {31'd0, write_ctrl_input}, 32'd0);
        check("rst_mem_ctrl", {30'd0, mem_ctrl_input}, 32'd0);
        check("rst_address", address, 32'd0);
        check("rst_w_data", w_data, 32'd0);
        check("rst_wr_value", write_pc_reg_value, 32'd0);
        check("rst_wr_addr", write_pc_reg_addr, 32'd0);
        check("rst_rs1_addr", load_pc_reg_addr1, 32'd0);
        check("rst_state", {29'd0, dbg_state}, {29'd0, ST_FETCH});
        reset_n = 1'b1;

        // ADDI x1,x0,5 then abort the following ADDI in DECODE
        run_instr(32'h0050_0093);
        imem[1] = 32'h0070_0293;   // ADDI x5,x0,7
        @(posedge clk);
        @(negedge clk);
        check("pre_abort_state", {29'd0, dbg_state}, {29'd0, ST_DECODE});
        reset_n = 1'b0;
        #1;
        check("abort_state", {29'd0, dbg_state}, {29'd0, ST_FETCH});
        check("abort_ins_addr", ins_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mpc = 32'h0;

        // Abort in WB: write strobe must fall at once
        imem[0] = 32'h0090_0313;   // ADDI x6,x0,9
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("wb_strobe_up", {31'd0, write_ctrl_input}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("wb_strobe_drop", {31'd0, write_ctrl_input}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mpc = 32'h0;

        // ADDI x0,x0,1: no register write
        run_instr(32'h0010_0013);

        // SW x2,8(x0) then LW x3,8(x0)
        do_reset();
        set_reg(2, 32'hDEAD_BEEF);
        run_instr(32'h0020_2423);
        run_instr(32'h0080_2183);
        check("lw_x3_env", xreg[3], 32'hDEAD_BEEF);

        // BEQ x0,x0,+8 taken
        do_reset();
        run_instr(32'h0000_0463);
        check("beq_target", ins_addr, 32'd2);
        // BNE x1,x0,+8 with x1=1 taken; BNE x1,x1,+8 not taken
        do_reset();
        set_reg(1, 32'd1);
        run_instr(32'h0000_9463);
        check("bne_taken", ins_addr, 32'd2);
        do_reset();
        run_instr(32'h0010_9463);
        check("bne_not_taken", ins_addr, 32'd1);

        // JAL x1,+16
        do_reset();
        run_instr(32'h0100_00EF);
        check("jal_target", ins_addr, 32'd4);

        // Random instruction stream against the model
        do_reset();
        for (int n = 0; n < 300; n++) run_instr(gen_instr());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv32_core.md
Name: riscv32_core

Overview:
- Multi-cycle RV32I integer core.
- The register file, instruction memory and data memory are all external, reached through word-indexed address/data buses; the system memory model serves all three.
- Each instruction runs through FETCH, DECODE, EXECUTE, MEM, WB: fixed CPI = 5, no pipelining.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first instruction.
- REG_BASE, 32'd0, word index in the external array where x0 resides; xN sits at REG_BASE+N.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- ins_data  input  32  instruction word at ins_addr
- load_pc_reg_value1  input  32  register value at load_pc_reg_addr1
- load_pc_reg_value2  input  32  register value at load_pc_reg_addr2
- read_data  input  32  data word at address
- write_ctrl_input  output  1  register write strobe
- mem_ctrl_input  output  2  [1]=data read, [0]=data write
- ins_addr  output  32  instruction word index = pc[31:2]
- load_pc_reg_addr1  output  32  REG_BASE+rs1
- load_pc_reg_addr2  output  32  REG_BASE+rs2
- write_pc_reg_value  output  32  register writeback data
- write_pc_reg_addr  output  32  REG_BASE+rd
- address  output  32  data word index = effective_addr[31:2]
- w_data  output  32  store data

Behaviour:
- External reads settle within the same cycle. The core samples every input at the rising edge that ends the state using it.
- Reset (asynchronous assert, synchronous release):
  - state=FETCH, pc=RESET_PC.
  - IR, A, B, ALU and MDR registers cleared.
  - write_ctrl_input=0, mem_ctrl_input=2'b00.
  - Address/data outputs read 0, except ins_addr=RESET_PC[31:2].
- FETCH: ins_addr=pc[31:2]; latch ins_data into IR.
- DECODE:
  - Drive the two register addresses from IR rs1/rs2.
  - Latch A and B. Index 0 forces 0, ignoring the external value.
  - Form the sign-extended I/S/B/U/J immediate.
- EXECUTE: ALU result and branch condition latched.
- MEM:
  - LW: mem_ctrl_input=2'b10, address=(A+immI)[31:2]; latch read_data into MDR.
  - SW: mem_ctrl_input=2'b01, address=(A+immS)[31:2], w_data=B.
  - All other instructions: 2'b00.
- WB:
  - write_ctrl_input=1 for rd-writing instructions only, and only when rd≠0.
  - write_pc_reg_addr=REG_BASE+rd.
  - pc updated at the end of WB.
- Strobes are asserted only in their state. Buses hold their derived values otherwise. mem_ctrl_input=2'b11 never occurs.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target LSB cleared).
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW: word only; other load/store funct3 values are treated as word.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Arithmetic and addressing:
  - 32-bit wrap-around arithmetic.
  - Shift amount is operand[4:0].
  - JAL/JALR link value = pc+4.
  - Branch target = pc+immB; not-taken next pc = pc+4.
  - Misaligned data addresses are silently truncated to a word.
- Unknown opcodes, FENCE and SYSTEM execute as NOP (pc+4, no writes, no strobes).
- reset_n low mid-instruction aborts it immediately; strobes drop asynchronously.

Decomposition:
- Shared package:
  - opcode constants.
  - funct3 constants.
  - state enum (FETCH, DECODE, EXECUTE, MEM, WB).
  - ALU-op enum.
  - mem_ctrl encodings (READ=2'b10, WRITE=2'b01, IDLE=2'b00).
- One sub-module: riscv32_alu (combinational; operands, ALU op, result, branch compare flags).
- Sequencer, immediate generation and datapath registers live in the top.

Test Plan:
- Reset, then release with RESET_PC=0 → cycle 1: ins_addr=0, all strobes 0; assert reset_n low mid-DECODE → state returns to FETCH and pc=0 at once.
- Memory word 0 = 0x00500093 (ADDI x1,x0,5) → 5th cycle: write_ctrl_input=1, write_pc_reg_addr=REG_BASE+1, write_pc_reg_value=5; next cycle ins_addr=1.
- Word 0 = 0x00100013 (ADDI x0,x0,1) → write_ctrl_input stays 0 for all five cycles.
- x2 externally=0xDEADBEEF, SW x2,8(x0) (0x00202423) → MEM cycle: mem_ctrl_input=01, address=2, w_data=0xDEADBEEF. Then LW x3,8(x0) (0x00802183) → MEM cycle: mem_ctrl_input=10, address=2; WB writes REG_BASE+3 with 0xDEADBEEF.
- BEQ x0,x0,+8 (0x00000463) at pc=0 → next FETCH ins_addr=2, no register/memory writes. With a load_pc_reg_value1 of 1 for a nonzero rs1 in BNE → taken; not taken for equal values → ins_addr=1.
- JAL x1,+16 (0x010000EF) at pc=0 → WB writes REG_BASE+1 with 4; next ins_addr=4.
